scroll_stripe_gen: RTL and testbench

SCROLL_STRIPE_GEN -- requirements
Module: scroll_stripe_gen

---
 rtl/stripe_pkg.sv | 42 ++++
 rtl/stripe_tile_rom.sv | 28 ++
 rtl/scroll_stripe_gen.sv | 114 +++++++++++
 tb/tb_scroll_stripe_gen.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stripe_pkg.sv
// Shared constants for the scrolling ground stripe: game-state codes, default
// geometry, the RGB332 ground/grass palette and the tile artwork.
package stripe_pkg;

  typedef logic [2:0] game_state_t;

  localparam game_state_t ST_IDLE  = 3'b000;
  localparam game_state_t ST_READY = 3'b001;
  localparam game_state_t ST_COUNT = 3'b010;
  localparam game_state_t ST_PLAY  = 3'b011;
  localparam game_state_t ST_OVER  = 3'b100;
  localparam game_state_t ST_PAUSE = 3'b101;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_BAND_TOP = 460;
  localparam int DEF_BAND_H   = 20;
  localparam int DEF_TILE_W   = 20;
  localparam int DEF_STEP_DIV = 2**19;

  localparam int         PAL_SIZE = 14;
  localparam logic [7:0] PAL_FILL = 8'b1001_1000;

  // Rows 0..5 are grass shades, 6..13 are soil/earth tones.
  localparam logic [7:0] PALETTE [PAL_SIZE] = '{
    8'h1C, 8'h38, 8'h14, 8'h31, 8'h0C, 8'h6C, 8'h88,
    8'hAC, 8'h64, 8'h8D, 8'hD1, 8'h44, 8'hA9, 8'h68
  };

  function automatic logic [7:0] palette_lookup(input logic [3:0] idx);
    if (idx >= 4'(PAL_SIZE)) return PAL_FILL;
    return PALETTE[idx];
  endfunction

  // Tile artwork: grass tips, grass body, a soil edge line, then textured earth.
  function automatic logic [3:0] tile_pattern(input int row, input int col);
    if (row < 2) return col[1] ? 4'd1 : 4'd0;
    if (row < 5) return 4'(2 + (row + col) % 3);
    if (row == 5) return 4'd5;
    return 4'(6 + (row * 3 + col) % 10);
  endfunction

endpackage

// File: rtl/stripe_tile_rom.sv
// Synchronous-read tile ROM, TILE_W*BAND_H entries of 4-bit palette index,
// contents elaborated from the package tile artwork.
module stripe_tile_rom
  import stripe_pkg::*;
#(
  parameter int  TILE_W = DEF_TILE_W,
  parameter int  BAND_H = DEF_BAND_H,
  localparam int DEPTH  = TILE_W * BAND_H,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] addr,
  output logic [3:0]    data
);

  logic [3:0] mem [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_rom
    assign mem[i] = tile_pattern(i / TILE_W, i % TILE_W);
  end

  always_ff @(posedge clk) begin
    if (rst) data <= '0;
    else     data <= mem[addr];
  end

endmodule

// File: rtl/scroll_stripe_gen.sv
// Horizontally scrolling ground stripe for a VGA band: prescaled scroll offset,
// divider-free tile phase tracking and a 3-stage address/ROM/palette pipeline.
module scroll_stripe_gen #(
  parameter int         H_ACTIVE = stripe_pkg::DEF_H_ACTIVE,
  parameter int         BAND_TOP = stripe_pkg::DEF_BAND_TOP,
  parameter int         BAND_H   = stripe_pkg::DEF_BAND_H,
  parameter int         TILE_W   = stripe_pkg::DEF_TILE_W,
  parameter int         STEP_DIV = stripe_pkg::DEF_STEP_DIV,
  parameter logic [2:0] ST_PLAY  = stripe_pkg::ST_PLAY
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  state,
  input  logic [10:0] hcounter,
  input  logic [10:0] vcounter,
  input  logic [2:0]  speed,
  output logic [7:0]  stripe_pixel,
  output logic        stripe_flag
);

  import stripe_pkg::*;

  localparam int PW    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int OW    = $clog2(TILE_W);
  localparam int SW    = OW + 3;
  localparam int DEPTH = TILE_W * BAND_H;
  localparam int AW    = $clog2(DEPTH);

  localparam logic [PW-1:0] PRESC_LAST = PW'(STEP_DIV - 1);
  localparam logic [OW-1:0] PHASE_LAST = OW'(TILE_W - 1);

  logic [PW-1:0] prescale;
  logic [OW-1:0] offset;
  logic [SW-1:0] offset_sum;
  logic          play;
  logic          step;

  logic [OW-1:0] phase_q;
  logic [OW-1:0] phase_cur;
  logic [10:0]   h_prev;
  logic          in_band;
  logic [AW-1:0] addr_cur;

  logic [AW-1:0] s1_addr;
  logic          s1_in_band;
  logic          s2_in_band;
  logic [3:0]    rom_data;

  assign play       = (state == ST_PLAY);
  assign step       = play && (prescale == PRESC_LAST);
  assign offset_sum = SW'(offset) + SW'(speed);

  always_ff @(posedge clk) begin
    if (rst) begin
      prescale <= '0;
      offset   <= '0;
    end else if (play) begin
      prescale <= step ? '0 : prescale + PW'(1);
      if (step) begin
        offset <= (offset_sum >= SW'(TILE_W)) ? OW'(offset_sum - SW'(TILE_W))
                                              : OW'(offset_sum);
      end
    end
  end

  // Phase follows (hcounter + offset) mod TILE_W by counting pixel changes,
  // reloaded at each line start so the scroll offset only changes per line.
  always_comb begin
    phase_cur = phase_q;
    if (hcounter == 11'd0) begin
      phase_cur = offset;
    end else if (hcounter != h_prev) begin
      phase_cur = (phase_q == PHASE_LAST) ? '0 : phase_q + OW'(1);
    end
  end

  assign in_band = (hcounter < 11'(H_ACTIVE)) &&
                   (vcounter >= 11'(BAND_TOP)) &&
                   (vcounter < 11'(BAND_TOP + BAND_H));

  assign addr_cur = in_band ? AW'(vcounter - 11'(BAND_TOP)) * AW'(TILE_W) + AW'(phase_cur)
                            : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q      <= '0;
      h_prev       <= '0;
      s1_addr      <= '0;
      s1_in_band   <= 1'b0;
      s2_in_band   <= 1'b0;
      stripe_pixel <= 8'h00;
      stripe_flag  <= 1'b0;
    end else begin
      phase_q      <= phase_cur;
      h_prev       <= hcounter;
      s1_addr      <= addr_cur;
      s1_in_band   <= in_band;
      s2_in_band   <= s1_in_band;
      stripe_flag  <= s2_in_band;
      stripe_pixel <= s2_in_band ? palette_lookup(rom_data) : 8'h00;
    end
  end

  stripe_tile_rom #(
    .TILE_W (TILE_W),
    .BAND_H (BAND_H)
  ) u_rom (
    .clk  (clk),
    .rst  (rst),
    .addr (s1_addr),
    .data (rom_data)
  );

endmodule

// File: tb/tb_scroll_stripe_gen.sv
// Self-checking bench for scroll_stripe_gen: reference model of prescaler,
// offset and phase feeding a 3-deep expected-output scoreboard.
module tb_scroll_stripe_gen;

  localparam int         TW   = 20;
  localparam int         DIV  = 4;
  localparam logic [2:0] PLAY = 3'b011;
  localparam logic [2:0] OVER = 3'b100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  state = 3'b000;
  logic [10:0] hcounter = 11'd0;
  logic [10:0] vcounter = 11'd0;
  logic [2:0]  speed = 3'd0;
  logic [7:0]  stripe_pixel;
  logic        stripe_flag;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    logic [7:0] pix;
    logic       flag;
  } exp_t;

  exp_t sbq[$];

  int m_presc = 0;
  int m_offset = 0;
  int m_phase = 0;
  int m_hprev = 0;

  logic [7:0] pal_tbl [16] = '{
    8'h1C, 8'h38, 8'h14, 8'h31, 8'h0C, 8'h6C, 8'h88, 8'hAC,
    8'h64, 8'h8D, 8'hD1, 8'h44, 8'hA9, 8'h68, 8'h98, 8'h98
  };

  scroll_stripe_gen #(
    .H_ACTIVE (640),
    .BAND_TOP (460),
    .BAND_H   (20),
    .TILE_W   (TW),
    .STEP_DIV (DIV),
    .ST_PLAY  (PLAY)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .state        (state),
    .hcounter     (hcounter),
    .vcounter     (vcounter),
    .speed        (speed),
    .stripe_pixel (stripe_pixel),
    .stripe_flag  (stripe_flag)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1);
  end

  function automatic int pat(input int row, input int col);
    if (row <= 1) return ((col / 2) % 2 == 1) ? 1 : 0;
    if (row <= 4) return 2 + (row + col) % 3;
    if (row == 5) return 5;
    return 6 + (3 * row + col) % 10;
  endfunction

  // One clock: drive h/v, advance the model, then compare the output due now.
  task automatic tick(input int h, input int v);
    exp_t e;
    exp_t z;
    int   ph;
    bit   inb;
    bit   stp;
    hcounter = 11'(h);
    vcounter = 11'(v);
    if (rst) begin
      m_presc = 0; m_offset = 0; m_phase = 0; m_hprev = 0;
      z.pix = 8'h00; z.flag = 1'b0;
      sbq.delete();
      sbq.push_back(z);
      sbq.push_back(z);
      @(posedge clk); #1;
      compared++;
      if (stripe_flag !== 1'b0 || stripe_pixel !== 8'h00) begin
        mismatched++;
        $display("FAIL reset_out: got flag=%b pix=%h want flag=0 pix=00", stripe_flag, stripe_pixel);
      end
    end else begin
      if (h == 0) ph = m_offset;
      else if (h != m_hprev) ph = (m_phase == TW - 1) ? 0 : m_phase + 1;
      else ph = m_phase;
      inb = (h < 640) && (v >= 460) && (v < 480);
      e.flag = inb;
      e.pix  = inb ? pal_tbl[4'(pat(v - 460, ph))] : 8'h00;
      sbq.push_back(e);
      stp = (state == PLAY) && (m_presc == DIV - 1);
      m_phase = ph;
      m_hprev = h;
      if (state == PLAY) begin
        m_presc = stp ? 0 : m_presc + 1;
        if (stp) m_offset = (m_offset + int'(speed)) % TW;
      end
      @(posedge clk); #1;
      if (sbq.size() == 3) begin
        e = sbq.pop_front();
        compared++;
        if (stripe_flag !== e.flag || stripe_pixel !== e.pix) begin
          mismatched++;
          $display("FAIL pipe_out h=%0d v=%0d: got flag=%b pix=%h want flag=%b pix=%h",
                   h, v, stripe_flag, stripe_pixel, e.flag, e.pix);
        end
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(0, 0);
    tick(0, 0);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    state = 3'b000;
    speed = 3'd0;
    rst = 1'b1;
    tick(100, 470);
    tick(100, 470);
    rst = 1'b0;
    tick(100, 470);
    tick(100, 470);
    tick(100, 470);
    compared++;
    if (stripe_flag !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_refill_flag: got %b want 1", stripe_flag);
    end
  endtask

  task automatic test_band_corners();
    int hs[8] = '{639, 640, 639, 640, 639, 640, 639, 640};
    int vs[8] = '{459, 459, 460, 460, 479, 479, 480, 480};
    int nflag = 0;
    for (int i = 0; i < 8; i++) begin
      tick(hs[i], vs[i]);
      if (i >= 2) nflag += int'(stripe_flag);
    end
    tick(700, 0); nflag += int'(stripe_flag);
    tick(700, 0); nflag += int'(stripe_flag);
    compared++;
    if (nflag != 2) begin
      mismatched++;
      $display("FAIL corner_flag_count: got %0d want 2", nflag);
    end
  endtask

  task automatic test_scroll();
    do_reset();
    state = PLAY;
    speed = 3'd3;
    for (int i = 0; i < 28; i++) tick(i, 465);
    compared++;
    if (int'(dut.offset) !== 1) begin
      mismatched++;
      $display("FAIL scroll_offset: got %0d want 1", dut.offset);
    end
    compared++;
    if (int'(dut.prescale) !== 0) begin
      mismatched++;
      $display("FAIL scroll_prescale: got %0d want 0", dut.prescale);
    end
  endtask

  task automatic test_freeze();
    state = PLAY;
    tick(28, 465);
    tick(29, 465);
    state = OVER;
    for (int i = 30; i < 35; i++) tick(i, 465);
    compared++;
    if (int'(dut.prescale) !== 2 || int'(dut.offset) !== 1) begin
      mismatched++;
      $display("FAIL freeze_hold: got presc=%0d off=%0d want presc=2 off=1", dut.prescale, dut.offset);
    end
    state = PLAY;
    tick(35, 465);
    tick(36, 465);
    compared++;
    if (int'(dut.prescale) !== 0 || int'(dut.offset) !== 4) begin
      mismatched++;
      $display("FAIL freeze_resume: got presc=%0d off=%0d want presc=0 off=4", dut.prescale, dut.offset);
    end
  endtask

  task automatic test_wrap();
    state = PLAY;
    speed = 3'd5;
    for (int i = 37; i < 49; i++) tick(i, 465);
    compared++;
    if (int'(dut.offset) !== 19) begin
      mismatched++;
      $display("FAIL wrap_pre_offset: got %0d want 19", dut.offset);
    end
    speed = 3'd7;
    for (int i = 49; i < 53; i++) tick(i, 465);
    compared++;
    if (int'(dut.offset) !== 6) begin
      mismatched++;
      $display("FAIL wrap_offset: got %0d want 6", dut.offset);
    end
    state = OVER;
    tick(0, 460);
    compared++;
    if (int'(dut.phase_q) !== 6) begin
      mismatched++;
      $display("FAIL wrap_line_phase: got %0d want 6", dut.phase_q);
    end
    for (int i = 1; i < 14; i++) tick(i, 460);
    compared++;
    if (int'(dut.s1_addr) !== 19) begin
      mismatched++;
      $display("FAIL wrap_addr_h13: got %0d want 19", dut.s1_addr);
    end
    tick(14, 460);
    compared++;
    if (int'(dut.s1_addr) !== 0) begin
      mismatched++;
      $display("FAIL wrap_addr_h14: got %0d want 0", dut.s1_addr);
    end
  endtask

  task automatic test_step_at_line_start();
    state = PLAY;
    speed = 3'd2;
    tick(20, 461);
    tick(21, 461);
    tick(22, 461);
    tick(0, 462);
    compared++;
    if (int'(dut.phase_q) !== 6 || int'(dut.offset) !== 8) begin
      mismatched++;
      $display("FAIL coincident_step: got phase=%0d off=%0d want phase=6 off=8", dut.phase_q, dut.offset);
    end
    state = OVER;
    for (int i = 1; i < 6; i++) tick(i, 462);
    tick(0, 463);
    compared++;
    if (int'(dut.phase_q) !== 8) begin
      mismatched++;
      $display("FAIL next_line_phase: got %0d want 8", dut.phase_q);
    end
  endtask

  task automatic test_back_to_back();
    int h = 0;
    int v;
    int r;
    for (int i = 0; i < 96; i++) begin
      if (i % 8 == 0) begin
        r = int'($urandom_range(0, 2));
        state = (r == 0) ? PLAY : (r == 1) ? OVER : 3'b000;
        speed = 3'($urandom_range(0, 7));
      end
      r = int'($urandom_range(0, 9));
      if (r == 0) h = 0;
      else if (r == 2) h = int'($urandom_range(630, 645));
      else if (r != 1) h = h + 1;
      v = int'($urandom_range(458, 482));
      tick(h, v);
    end
    compared++;
    if (int'(dut.offset) !== m_offset || int'(dut.prescale) !== m_presc) begin
      mismatched++;
      $display("FAIL random_state: got off=%0d presc=%0d want off=%0d presc=%0d",
               dut.offset, dut.prescale, m_offset, m_presc);
    end
    tick(700, 0);
    tick(700, 0);
  endtask

  initial begin
    test_reset();
    test_band_corners();
    test_scroll();
    test_freeze();
    test_wrap();
    test_step_at_line_start();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
